// File: rtl/pe_mac_sequencer.sv
// Sequencer for one PE row: clear / bias / MAC / output passes with a valid/ready hand-off.
// Optional macro PE_SEQ_STALL_CNT_EN adds a saturating 32-bit output-stall counter port.
module pe_mac_sequencer #(
    parameter int CNT_WIDTH = 16,
    parameter int CR_WIDTH  = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] num_mac,
    input  logic [CNT_WIDTH-1:0] num_out,
    input  logic                 relu_en,
    input  logic                 shift_en,
    input  logic                 out_ready,
    output logic [CR_WIDTH-1:0]  cr,
    output logic                 enable_mac,
    output logic                 clear_mac,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 done
`ifdef PE_SEQ_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        BIAS  = 3'd2,
        MAC   = 3'd3,
        OUT   = 3'd4
    } state_t;

    // Fixed control-select patterns; ReLU and shift bits are added in OUT from the latched config.
    localparam logic [CR_WIDTH-1:0] BIAS_CR = CR_WIDTH'((1 << 13) | (1 << 7));
    localparam logic [CR_WIDTH-1:0] MAC_CR  = CR_WIDTH'(1 << 5);
    localparam logic [CR_WIDTH-1:0] OUT_CR  = CR_WIDTH'(1 << 1);
    localparam logic [CR_WIDTH-1:0] RELU_CR = CR_WIDTH'(1 << 2);
    localparam logic [CR_WIDTH-1:0] SHFT_CR = CR_WIDTH'(1 << 14);

    state_t               state_reg;
    logic [CNT_WIDTH-1:0] mac_cnt_reg;
    logic [CNT_WIDTH-1:0] out_cnt_reg;
    logic [CNT_WIDTH-1:0] num_mac_reg;
    logic [CNT_WIDTH-1:0] num_out_reg;
    logic                 relu_reg;
    logic                 shift_reg;
    logic                 done_reg;
    logic                 abort_clr_reg;
    logic [CNT_WIDTH:0]   out_cnt_inc;

    // One extra bit so num_out = all-ones compares without wrap.
    assign out_cnt_inc = {1'b0, out_cnt_reg} + (CNT_WIDTH + 1)'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            mac_cnt_reg   <= '0;
            out_cnt_reg   <= '0;
            num_mac_reg   <= '0;
            num_out_reg   <= '0;
            relu_reg      <= 1'b0;
            shift_reg     <= 1'b0;
            done_reg      <= 1'b0;
            abort_clr_reg <= 1'b0;
        end else begin
            done_reg      <= 1'b0;
            abort_clr_reg <= 1'b0;
            if (abort) begin
                abort_clr_reg <= (state_reg != IDLE);
                state_reg     <= IDLE;
                mac_cnt_reg   <= '0;
                out_cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            num_mac_reg <= num_mac;
                            num_out_reg <= num_out;
                            relu_reg    <= relu_en;
                            shift_reg   <= shift_en;
                            out_cnt_reg <= '0;
                            if (num_out == '0) begin
                                done_reg <= 1'b1;
                            end else begin
                                state_reg <= CLEAR;
                            end
                        end
                    end
                    CLEAR: state_reg <= BIAS;
                    BIAS: begin
                        if (num_mac_reg == '0) begin
                            state_reg <= OUT;
                        end else begin
                            mac_cnt_reg <= num_mac_reg - CNT_WIDTH'(1);
                            state_reg   <= MAC;
                        end
                    end
                    MAC: begin
                        if (mac_cnt_reg == '0) begin
                            state_reg <= OUT;
                        end else begin
                            mac_cnt_reg <= mac_cnt_reg - CNT_WIDTH'(1);
                        end
                    end
                    OUT: begin
                        if (out_ready) begin
                            if (out_cnt_inc < {1'b0, num_out_reg}) begin
                                out_cnt_reg <= out_cnt_inc[CNT_WIDTH-1:0];
                                state_reg   <= CLEAR;
                            end else begin
                                out_cnt_reg <= '0;
                                state_reg   <= IDLE;
                                done_reg    <= 1'b1;
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    logic in_bias;
    logic in_mac;
    logic in_out;

    assign in_bias    = (state_reg == BIAS);
    assign in_mac     = (state_reg == MAC);
    assign in_out     = (state_reg == OUT);
    assign enable_mac = in_bias | in_mac;
    assign clear_mac  = (state_reg == CLEAR) | abort_clr_reg;
    assign out_valid  = in_out;
    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;

    for (genvar gi = 0; gi < CR_WIDTH; gi++) begin : g_cr
        assign cr[gi] = (in_bias & BIAS_CR[gi])
                      | (in_mac  & MAC_CR[gi])
                      | (in_out  & (OUT_CR[gi]
                                    | (relu_reg  & RELU_CR[gi])
                                    | (shift_reg & SHFT_CR[gi])));
    end

`ifdef PE_SEQ_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == IDLE) && start && !abort) begin
            stall_cnt_reg <= '0;
        end else if (in_out && !out_ready && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: doc/pe_mac_sequencer.md
Name: pe_mac_sequencer

Overview:
Sequences one processing element through repeated bias-load / MAC / activate / output passes for a convolution or dense layer.
Drives the PE's 15-bit control-select bus, enable_mac and clear_mac, and hands each finished activation to the writeback path over a valid/ready handshake.
Sits between the layer controller (start/config) and one PE row; all PEs in the row share its outputs.

Parameters:
CNT_WIDTH, 16, width of MAC-length and output-count fields
CR_WIDTH, 15, width of the PE control-select bus (cr[0]..cr[14])

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous active-low reset
start  in  1  single-cycle layer start; accepted only in IDLE
abort  in  1  synchronous abort, highest priority after reset
num_mac  in  CNT_WIDTH  MAC cycles per output (sampled on accepted start)
num_out  in  CNT_WIDTH  outputs per layer (sampled on accepted start)
relu_en  in  1  apply ReLU at output (sampled on start)
shift_en  in  1  apply fixed-point shift at output (sampled on start)
out_ready  in  1  writeback ready
cr  out  CR_WIDTH  PE control selects, bit i drives cr_i
enable_mac  out  1  PE MAC enable
clear_mac  out  1  PE accumulator clear
out_valid  out  1  PE output holds a finished activation
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last output handshake

Behaviour:
- Reset (async, reset=0): state=IDLE; cr=0, enable_mac=0, clear_mac=0, out_valid=0, busy=0, done=0; counters cleared.
- All outputs are decoded from the state register only (Moore); no input-to-output combinational path.
- Unlisted cr bits are 0 in every state.
- IDLE:
  - All outputs are 0.
  - start=1 latches num_mac, num_out, relu_en and shift_en, and moves to CLEAR.
  - start with num_out=0: done pulses next cycle and the state stays IDLE.
- CLEAR, 1 cycle:
  - clear_mac=1, enable_mac=0.
  - Next state BIAS.
- BIAS, 1 cycle:
  - enable_mac=1; cr[13]=1 (bias into adder), cr[7]=1 (zero second operand).
  - The accumulator loads the bias.
  - Next state is MAC, or OUT when num_mac=0.
- MAC, exactly num_mac cycles:
  - enable_mac=1; cr[5]=1 (accumulator feedback); cr[0], cr[1], cr[7] and cr[13] are 0.
  - mac_cnt loads num_mac-1 on entry and decrements each cycle.
  - Leaves for OUT in the cycle mac_cnt=0.
- OUT:
  - enable_mac=0; cr[1]=1 (accumulator hold); cr[2]=relu_en_q; cr[14]=shift_en_q; out_valid=1.
  - Holds while out_ready=0; out_valid stays high, and cr and the accumulator stay stable.
  - On out_ready=1, out_cnt increments.
  - If out_cnt+1 < num_out, the next state is CLEAR (next output); otherwise the next state is IDLE and done=1 for that one cycle.
- Latency:
  - Per output = 2 + num_mac + 1 cycles, plus stall cycles.
  - Start to first out_valid = 3 + num_mac cycles.
- abort=1 in any state:
  - Next state IDLE; done is not pulsed.
  - clear_mac=1 for exactly one cycle on the IDLE entry; counters reset.
  - In the same cycle, abort overrides start and out_ready.
- start while busy=1 is ignored. Config inputs are don't-care outside the accepted start cycle.
- Counters:
  - Counters are unsigned CNT_WIDTH.
  - num_mac = 2^CNT_WIDTH-1 is legal with no wrap.
  - out_cnt never exceeds num_out-1.
- Reset asserted mid-operation: immediate return to reset values, with no done pulse.

Optional Feature:
PE_SEQ_STALL_CNT_EN: adds output port stall_cnt (32-bit).
- Counts cycles with out_valid=1 and out_ready=0.
- Clears on accepted start and on reset; saturates at all-ones.
- Without the macro, the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then start with num_mac=4, num_out=1, out_ready=1:
  - CLEAR, BIAS, MAC x4, then OUT at cycle 7 after start.
  - done pulses 1 cycle; enable_mac high exactly 5 cycles.
- num_mac=0, num_out=3, relu_en=1:
  - Three CLEAR/BIAS/OUT passes with cr[2]=1 in OUT and no MAC cycles.
  - One done pulse after the third handshake.
- out_ready held low for 10 cycles in OUT:
  - out_valid, cr[1]=1 and cr[14] stay stable.
  - stall_cnt=10 when the macro is defined.
  - The handshake completes on the first ready cycle.
- abort in MAC cycle 2 of num_mac=8:
  - IDLE next cycle, clear_mac=1 for one cycle, no done.
  - A subsequent start works normally.
- start pulsed while busy and num_out=0 start in IDLE:
  - The first is ignored (config unchanged).
  - The second gives a done pulse 1 cycle later with busy never high.
- reset deasserted then asserted mid-OUT:
  - All outputs return to 0 asynchronously, before the next clock edge.
